// File: rtl/vend_pkg.sv
// Shared types and helpers for the coin credit accumulator: the refund FSM
// states, default denominations and the greedy "largest coin that fits" search.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RF_SEL = 2'd1,
      RF_GAP = 2'd2
   } state_t;

   // Default denominations, channel 0 holds the largest coin.
   localparam int QUARTER = 25;
   localparam int DIME    = 10;
   localparam int NICKEL  = 5;

   // Fixed-size search table: channels beyond the instance's NUM_COINS are
   // disabled via the enable mask. Credit and coin values must fit VAL_W bits.
   localparam int MAX_COINS = 8;
   localparam int IDX_W     = 3;
   localparam int VAL_W     = 16;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } fit_t;

   // Lowest enabled index whose value does not exceed credit. Denominations
   // descend with index, so this is the largest coin that still fits.
   function automatic fit_t largest_fit(input logic [VAL_W-1:0]                credit,
                                        input logic [MAX_COINS-1:0][VAL_W-1:0] vals,
                                        input logic [MAX_COINS-1:0]            en);
      fit_t f;
      f = '0;
      for (int i = MAX_COINS - 1; i >= 0; i--) begin
         if (en[i] && (vals[i] <= credit)) begin
            f.valid = 1'b1;
            f.idx   = IDX_W'(i);
         end
      end
      return f;
   endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Rising-edge detector for the coin sensor levels. The history register resets
// to all ones so a coin that is already high when reset releases is ignored.
module coin_edge_detect #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] coin_i,
   output logic [W-1:0] edge_o
);

   logic [W-1:0] coin_q;

   // Previous-cycle sensor levels, sampled in every state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) coin_q <= '1;
      else       coin_q <= coin_i;
   end

   assign edge_o = coin_i & ~coin_q;

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: counts coin insertions into a saturating credit
// register, services vend debits with ok/fail pulses and returns credit as
// one-hot coin-eject pulses (largest coin first) through a small refund FSM.
module coin_credit_accumulator
   import vend_pkg::*;
#(
   parameter int                         NUM_COINS  = 3,
   parameter int                         CNT_W      = 10,
   parameter logic [NUM_COINS*CNT_W-1:0] COIN_VAL   = {CNT_W'(NICKEL), CNT_W'(DIME), CNT_W'(QUARTER)},
   parameter int                         MAX_CREDIT = 1000
) (
   input  logic                 clk,
   input  logic                 resetCount,
   input  logic [NUM_COINS-1:0] coin_in,
   input  logic                 debit_req,
   input  logic [CNT_W-1:0]     debit_amt,
   input  logic                 refund_req,
   output logic [CNT_W-1:0]     outCount,
   output logic                 debit_ok,
   output logic                 debit_fail,
   output logic                 overflow,
   output logic                 coin_reject,
   output logic [NUM_COINS-1:0] refund_coin,
   output logic                 refund_done,
   output logic                 busy
);

   // Two guard bits so credit + a full set of simultaneous coins cannot wrap
   // before the saturation compare.
   localparam int SUM_W = CNT_W + 2;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ok_q, ok_d;
   logic                   fail_q, fail_d;
   logic                   ovf_q, ovf_d;
   logic                   rej_q, rej_d;
   logic [NUM_COINS-1:0]   rc_q, rc_d;
   logic                   done_q, done_d;

   logic [NUM_COINS-1:0]        coin_edge;
   logic [SUM_W-1:0]            add;
   logic [SUM_W-1:0]            deb;
   logic [SUM_W-1:0]            nxt;
   logic [MAX_COINS-1:0][VAL_W-1:0] fit_vals;
   logic [MAX_COINS-1:0]        fit_en;
   fit_t                        fit;
   logic [VAL_W-1:0]            sel_val;

   coin_edge_detect #(.W(NUM_COINS)) u_edge (
      .clk_i  (clk),
      .rst_i  (resetCount),
      .coin_i (coin_in),
      .edge_o (coin_edge)
   );

   // Spread the packed denomination parameter into the fixed search table.
   for (genvar g = 0; g < MAX_COINS; g++) begin : g_fit
      if (g < NUM_COINS) begin : g_on
         assign fit_vals[g] = VAL_W'(COIN_VAL[g*CNT_W +: CNT_W]);
         assign fit_en[g]   = 1'b1;
      end else begin : g_off
         assign fit_vals[g] = '0;
         assign fit_en[g]   = 1'b0;
      end
   end

   assign fit     = largest_fit(VAL_W'(cnt_q), fit_vals, fit_en);
   assign sel_val = fit_vals[fit.idx];

   // Total value of all coins whose edge arrived this cycle.
   always_comb begin
      add = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (coin_edge[i]) add = add + SUM_W'(COIN_VAL[i*CNT_W +: CNT_W]);
      end
   end

   // Next-state, credit update and pulse generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
      ovf_d   = 1'b0;
      rej_d   = 1'b0;
      rc_d    = '0;
      done_d  = 1'b0;
      deb     = '0;
      nxt     = '0;

      case (state_q)
         IDLE: begin
            // Debit is judged against credit before this cycle's coins land.
            if (debit_req) begin
               if (debit_amt <= cnt_q) begin
                  ok_d = 1'b1;
                  deb  = SUM_W'(debit_amt);
               end else begin
                  fail_d = 1'b1;
               end
            end
            nxt = SUM_W'(cnt_q) - deb + add;
            if (nxt > SUM_W'(MAX_CREDIT)) begin
               cnt_d = CNT_W'(MAX_CREDIT);
               ovf_d = 1'b1;
            end else begin
               cnt_d = nxt[CNT_W-1:0];
            end
            // A debit in the same cycle wins; the refund level retries later.
            if (refund_req && !debit_req) state_d = RF_SEL;
         end

         RF_SEL: begin
            if (fit.valid) begin
               for (int i = 0; i < NUM_COINS; i++) rc_d[i] = (int'(fit.idx) == i);
               cnt_d   = cnt_q - sel_val[CNT_W-1:0];
               state_d = RF_GAP;
            end else begin
               // Nothing fits: any sub-nickel remainder stays as credit.
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         RF_GAP: state_d = RF_SEL;

         default: state_d = IDLE;
      endcase

      // During a refund coins are bounced and vends refused.
      if (state_q != IDLE) begin
         if (|coin_edge) rej_d  = 1'b1;
         if (debit_req)  fail_d = 1'b1;
      end
   end

   // State, credit and registered pulse outputs; reset drops everything at once.
   always_ff @(posedge clk or posedge resetCount) begin
      if (resetCount) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         fail_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rej_q   <= 1'b0;
         rc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
         ovf_q   <= ovf_d;
         rej_q   <= rej_d;
         rc_q    <= rc_d;
         done_q  <= done_d;
      end
   end

   assign outCount    = cnt_q;
   assign debit_ok    = ok_q;
   assign debit_fail  = fail_q;
   assign overflow    = ovf_q;
   assign coin_reject = rej_q;
   assign refund_coin = rc_q;
   assign refund_done = done_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator: a behavioural credit/refund-schedule
// model checked against the DUT every negedge, plus literal expectations per step.
module tb_coin_credit_accumulator;

   logic       clk = 1'b0;
   logic       resetCount;
   logic [2:0] coin_in;
   logic       debit_req;
   logic [9:0] debit_amt;
   logic       refund_req;
   logic [9:0] outCount;
   logic       debit_ok, debit_fail, overflow, coin_reject, refund_done, busy;
   logic [2:0] refund_coin;

   int n_vec = 0;
   int n_err = 0;

   coin_credit_accumulator dut (
      .clk         (clk),
      .resetCount  (resetCount),
      .coin_in     (coin_in),
      .debit_req   (debit_req),
      .debit_amt   (debit_amt),
      .refund_req  (refund_req),
      .outCount    (outCount),
      .debit_ok    (debit_ok),
      .debit_fail  (debit_fail),
      .overflow    (overflow),
      .coin_reject (coin_reject),
      .refund_coin (refund_coin),
      .refund_done (refund_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         vals [3] = '{25, 10, 5};
   int         m_credit, t, add, nxt, c;
   int         plan [$];
   bit         found;
   logic [2:0] m_prev, ed;
   int         e_cnt;
   logic       e_ok, e_fail, e_ovf, e_rej, e_done, e_busy;
   logic [2:0] e_rc;

   always @(posedge clk or posedge resetCount) begin
      if (resetCount) begin
         m_credit = 0; t = 0; m_prev = 3'b111; plan.delete();
         e_cnt = 0; e_ok = 0; e_fail = 0; e_ovf = 0; e_rej = 0; e_done = 0; e_busy = 0; e_rc = 0;
      end else begin
         ed = coin_in & ~m_prev;
         m_prev = coin_in;
         e_ok = 0; e_fail = 0; e_ovf = 0; e_rej = 0; e_done = 0; e_rc = 0;
         if (t == 0) begin
            add = 0;
            for (int i = 0; i < 3; i++) if (ed[i]) add += vals[i];
            nxt = m_credit + add;
            if (debit_req) begin
               if (int'(debit_amt) <= m_credit) begin e_ok = 1; nxt -= int'(debit_amt); end
               else e_fail = 1;
            end
            if (nxt > 1000) begin m_credit = 1000; e_ovf = 1; end
            else m_credit = nxt;
            if (refund_req && !debit_req) begin
               // Greedy coin list for the whole refund, largest first.
               t = 1; plan.delete(); c = m_credit;
               do begin
                  found = 0;
                  for (int i = 0; i < 3; i++)
                     if (!found && vals[i] <= c) begin plan.push_back(i); c -= vals[i]; found = 1; end
               end while (found);
            end
         end else begin
            if (ed != 0) e_rej = 1;
            if (debit_req) e_fail = 1;
            // Refund timeline: coin k ejects at phase 2k, done at phase 2*N+2.
            t++;
            if (t == 2 * plan.size() + 2) begin e_done = 1; t = 0; end
            else if (t % 2 == 0) begin
               m_credit -= vals[plan[t/2-1]];
               e_rc = 3'(1 << plan[t/2-1]);
            end
         end
         e_busy = (t != 0);
         e_cnt  = m_credit;
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      chk("m_outCount",    32'(outCount),    32'(e_cnt));
      chk("m_debit_ok",    32'(debit_ok),    32'(e_ok));
      chk("m_debit_fail",  32'(debit_fail),  32'(e_fail));
      chk("m_overflow",    32'(overflow),    32'(e_ovf));
      chk("m_coin_reject", 32'(coin_reject), 32'(e_rej));
      chk("m_refund_coin", 32'(refund_coin), 32'(e_rc));
      chk("m_refund_done", 32'(refund_done), 32'(e_done));
      chk("m_busy",        32'(busy),        32'(e_busy));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetCount = 1'b1; coin_in = 0; debit_req = 0; debit_amt = 0; refund_req = 0;
      repeat (3) @(posedge clk);
      #1 resetCount = 1'b0;
      chk("rst_cnt",  32'(outCount), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rc",   32'(refund_coin), 0);
      tick();

      // 1: quarter held for three cycles counts once
      coin_in = 3'b001; tick(); chk("t1_first", 32'(outCount), 25);
      tick(); tick();
      coin_in = 3'b000; tick(); chk("t1_held", 32'(outCount), 25);
      debit_req = 1; debit_amt = 25; tick(); chk("t1_clr_ok", 32'(debit_ok), 1); chk("t1_clr", 32'(outCount), 0);
      debit_req = 0;

      // 2: three simultaneous coins
      coin_in = 3'b111; tick(); chk("t2_sum", 32'(outCount), 40); chk("t2_ovf", 32'(overflow), 0);
      coin_in = 3'b000; tick();

      // 3: debits
      debit_req = 1; debit_amt = 35; tick(); chk("t3_ok", 32'(debit_ok), 1); chk("t3_cnt5", 32'(outCount), 5);
      debit_amt = 10; tick(); chk("t3_fail", 32'(debit_fail), 1); chk("t3_keep5", 32'(outCount), 5);
      debit_amt = 5; coin_in = 3'b010; tick(); chk("t3_ok2", 32'(debit_ok), 1); chk("t3_cnt10", 32'(outCount), 10);
      debit_req = 0; coin_in = 3'b000; tick();

      // 4: saturation
      for (int k = 0; k < 39; k++) begin
         coin_in = 3'b001; tick();
         coin_in = 3'b000; tick();
      end
      coin_in = 3'b100; tick(); chk("t4_990", 32'(outCount), 990);
      coin_in = 3'b000; tick();
      coin_in = 3'b001; tick(); chk("t4_sat", 32'(outCount), 1000); chk("t4_ovf", 32'(overflow), 1);
      coin_in = 3'b000; tick(); chk("t4_ovf_low", 32'(overflow), 0);
      coin_in = 3'b100; tick(); chk("t4_sat2", 32'(outCount), 1000); chk("t4_ovf2", 32'(overflow), 1);
      coin_in = 3'b000; tick();

      // 5: refund of 45 -> 25, 10, 10
      debit_req = 1; debit_amt = 955; tick(); chk("t5_45", 32'(outCount), 45);
      debit_req = 0; refund_req = 1; tick(); chk("t5_busy1", 32'(busy), 1);
      refund_req = 0; tick(); chk("t5_rc25", 32'(refund_coin), 1); chk("t5_cnt20", 32'(outCount), 20);
      coin_in = 3'b100; tick(); chk("t5_gap1", 32'(refund_coin), 0); chk("t5_rej", 32'(coin_reject), 1);
      chk("t5_norej_cnt", 32'(outCount), 20);
      coin_in = 3'b000; tick(); chk("t5_rc10a", 32'(refund_coin), 2); chk("t5_cnt10", 32'(outCount), 10);
      debit_req = 1; debit_amt = 0; tick(); chk("t5_busy_fail", 32'(debit_fail), 1); chk("t5_gap2", 32'(refund_coin), 0);
      debit_req = 0; tick(); chk("t5_rc10b", 32'(refund_coin), 2); chk("t5_cnt0", 32'(outCount), 0);
      tick(); chk("t5_busy7", 32'(busy), 1);
      tick(); chk("t5_done", 32'(refund_done), 1); chk("t5_idle", 32'(busy), 0);

      // debit of 0, remainder refund, debit priority over refund
      debit_req = 1; debit_amt = 0; tick(); chk("d0_ok", 32'(debit_ok), 1); chk("d0_cnt", 32'(outCount), 0);
      debit_req = 0; coin_in = 3'b100; tick(); chk("n_5", 32'(outCount), 5);
      coin_in = 3'b000; debit_req = 1; debit_amt = 2; tick(); chk("rem_3", 32'(outCount), 3);
      debit_amt = 1; refund_req = 1; tick(); chk("prio_ok", 32'(debit_ok), 1); chk("prio_idle", 32'(busy), 0);
      chk("prio_cnt", 32'(outCount), 2);
      debit_req = 0; tick(); chk("rem_busy", 32'(busy), 1);
      refund_req = 0; tick(); chk("rem_done", 32'(refund_done), 1); chk("rem_keep", 32'(outCount), 2);
      chk("rem_norc", 32'(refund_coin), 0);

      // 6: asynchronous reset during an eject pulse
      debit_req = 1; debit_amt = 2; tick();
      debit_req = 0; coin_in = 3'b111; tick(); chk("t6_40", 32'(outCount), 40);
      coin_in = 3'b000; refund_req = 1; tick();
      refund_req = 0; tick(); chk("t6_rc", 32'(refund_coin), 1); chk("t6_15", 32'(outCount), 15);
      coin_in = 3'b001;
      #2 resetCount = 1'b1;
      #1;
      chk("t6_async_cnt",  32'(outCount), 0);
      chk("t6_async_rc",   32'(refund_coin), 0);
      chk("t6_async_busy", 32'(busy), 0);
      @(posedge clk); @(posedge clk);
      #1 resetCount = 1'b0;
      tick(); chk("t6_held", 32'(outCount), 0);
      coin_in = 3'b000; tick();
      coin_in = 3'b001; tick(); chk("t6_after", 32'(outCount), 25);
      coin_in = 3'b000; tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
Parametrised successor to the vending-machine coin counter. Accepts NUM_COINS coin-sensor channels with configurable denominations and counts each insertion once, on its rising edge. Holds a saturating credit register, services debit (vend) requests with an ok/fail handshake, and runs a refund state machine that returns credit as one-hot coin pulses, largest denomination first. Sits between the coin sensors and the vend controller.

Parameters:
NUM_COINS, 3, number of coin channels.
CNT_W, 10, width of the credit register.
COIN_VAL, {25,10,5} (CNT_W bits each, channel 0 = 25), denomination per channel; strictly descending by index.
MAX_CREDIT, 1000, saturation ceiling; must be ≤ 2^CNT_W-1.

Ports:
clk  in  1  rising-edge clock
resetCount  in  1  asynchronous, active-high reset
coin_in  in  NUM_COINS  coin sensor levels, synchronous to clk (synchronisers live upstream)
debit_req  in  1  single-cycle vend debit request
debit_amt  in  CNT_W  price to deduct, sampled with debit_req
refund_req  in  1  level; request return of all credit
outCount  out  CNT_W  current credit
debit_ok  out  1  1-cycle pulse: debit applied
debit_fail  out  1  1-cycle pulse: insufficient credit, no change
overflow  out  1  1-cycle pulse: credit clipped at MAX_CREDIT
coin_reject  out  1  1-cycle pulse: coin edge arrived during refund and was not credited
refund_coin  out  NUM_COINS  one-hot 1-cycle coin-eject pulse
refund_done  out  1  1-cycle pulse at end of refund
busy  out  1  high while not IDLE

Behaviour:
- Reset (asynchronous, active-high): outCount=0; all pulse outputs=0; busy=0; state=IDLE; coin_q = all ones, so a coin held high through reset is not counted.
- Edge detect: edge[i] = coin_in[i] & ~coin_q[i]; coin_q <= coin_in every cycle in every state.
- IDLE credit update, registered, 1-cycle latency:
  - add = sum of COIN_VAL[i] over all set edge[i]; simultaneous edges are summed in the same cycle.
  - If debit_req, the debit is judged against the current outCount, before this cycle's coins are added.
  - debit_amt ≤ outCount: debit_ok=1, subtract debit_amt.
  - Otherwise: debit_fail=1, no subtraction.
  - next = outCount - debit_applied + add, computed at CNT_W+2 bits. If next > MAX_CREDIT: outCount=MAX_CREDIT and overflow=1.
- Refund entry: in IDLE, when refund_req=1 and debit_req=0, go to RF_SEL. Debit has priority; refund_req is a level and is honoured on the next eligible cycle.
- States:
  - IDLE.
  - RF_SEL: find the lowest index i with COIN_VAL[i] ≤ outCount.
    - Found: refund_coin = one-hot(i), outCount -= COIN_VAL[i], go to RF_GAP.
    - None found (credit 0 or below the smallest denomination): refund_done=1, go to IDLE. Any remainder stays in outCount.
  - RF_GAP: refund_coin=0 for exactly 1 cycle, then go to RF_SEL.
- Rules while not IDLE:
  - Every coin edge pulses coin_reject for 1 cycle and is not credited.
  - debit_req gets debit_fail.
  - refund_req is ignored.
- Mid-operation reset: the asynchronous reset drops refund_coin immediately and zeroes credit. No partial pulse is stretched.
- Debit of 0: always debit_ok, credit unchanged.

Decomposition:
- Package vend_pkg holds:
  - state enum {IDLE, RF_SEL, RF_GAP};
  - default denomination constants QUARTER=25, DIME=10, NICKEL=5;
  - a function largest_fit(credit) returning the channel index and a valid flag.
- Sub-module coin_edge_detect (parametrised width, holds coin_q and its reset-to-ones behaviour). All other logic stays in the top module.

Test Plan:
1. After reset, hold coin_in[0]=1 for 3 cycles, then 0 → outCount=25 one cycle after the first high sample; stays 25, not 75.
2. Set coin_in=3'b111 for one cycle from credit 0 → outCount=40 next cycle, no overflow.
3. Credit 40: debit_req with amt=35 → debit_ok, outCount=5. Then amt=10 → debit_fail, outCount stays 5. Debit amt=5 in the same cycle as a dime edge, from credit 5 → debit_ok, outCount=10.
4. Credit 990, quarter edge → outCount=1000 with an overflow pulse. A further nickel → remains 1000, overflow pulses again.
5. Credit 45, refund_req=1:
   - refund_coin pulses 001 (25), 010 (10), 010 (10), each separated by a 1-cycle gap;
   - refund_done follows; outCount=0; busy high throughout;
   - a nickel edge mid-refund → coin_reject and no credit change.
6. Assert resetCount mid-refund, while refund_coin is high (credit 40) → asynchronously outCount=0, refund_coin=0, busy=0. After release, a coin still held high is not counted.
